rgb2hsv_pipe: RTL and testbench

RGB2HSV_PIPE -- requirements
Module: rgb2hsv_pipe

---
 rtl/rgb2hsv_pkg.sv | 15 +
 rtl/rgb2hsv_div.sv | 25 ++
 rtl/rgb2hsv_pipe.sv | 157 +++++++++++++++
 tb/tb_rgb2hsv_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2hsv_pkg.sv
// Shared constants and types for the RGB-to-HSV pipeline: hue constants and sector encoding.
package rgb2hsv_pkg;

   localparam logic [8:0] HUE_60  = 9'd60;
   localparam logic [8:0] HUE_120 = 9'd120;
   localparam logic [8:0] HUE_240 = 9'd240;
   localparam logic [8:0] HUE_360 = 9'd360;

   typedef enum logic [1:0] {
      SEC_R = 2'd0,
      SEC_G = 2'd1,
      SEC_B = 2'd2
   } sector_t;

endpackage

// File: rtl/rgb2hsv_div.sv
// Combinational unsigned floor divider; a zero divisor yields a zero quotient.
module rgb2hsv_div #(
   parameter int NW = 16,
   parameter int DW = 8,
   parameter int QW = 8
) (
   input  logic [NW-1:0] num,
   input  logic [DW-1:0] den,
   output logic [QW-1:0] quo
);

   logic [NW-1:0] full;

   // Quotient with divide-by-zero forced to 0, truncated to the result width
   always_comb begin
      full = '0;
      if (den == '0) begin
         full = '0;
      end else begin
         full = num / NW'(den);
      end
      quo = full[QW-1:0];
   end

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Four-stage RGB-to-HSV converter with a single global advance for backpressure.
// Optional macro RGB2HSV_PIPE_CNT_EN adds a saturating output-transfer counter (out_cnt).
module rgb2hsv_pipe
   import rgb2hsv_pkg::*;
#(
   parameter int CW = 8,
   parameter int HF = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3*CW-1:0]   in_rgb,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [9+HF-1:0]   out_h,
   output logic [CW-1:0]     out_s,
   output logic [CW-1:0]     out_v
`ifdef RGB2HSV_PIPE_CNT_EN
   ,output logic [31:0]      out_cnt
`endif
);

   localparam int HW = 9 + HF;
   // Hue numerator reaches 360*delta*2^HF; extra headroom keeps the signed sum exact
   localparam int NW = CW + HF + 11;

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic [CW-1:0]        r, g, b, cmax_c, cmin_c;
   sector_t              sec_c;
   logic signed [CW:0]   n_c;

   logic                 v1, v2, v3;
   logic [CW-1:0]        cmax1, delta1, cmax2, delta2, cmax3;
   sector_t              sec1;
   logic signed [CW:0]   n1;
   logic [NW-1:0]        hnum2;
   logic [2*CW-1:0]      snum2;
   logic [HW-1:0]        h3, hq;
   logic [CW-1:0]        s3, sq;

   logic [8:0]           off_c;
   logic signed [NW-1:0] hsum_c;
   logic [NW-1:0]        hnum_c;
   logic [2*CW-1:0]      snum_c;

   // Stage-1 combinational: extremes, sector (ties R > G > B) and signed hue numerator term
   always_comb begin
      r = in_rgb[3*CW-1:2*CW];
      g = in_rgb[2*CW-1:CW];
      b = in_rgb[CW-1:0];
      if (r >= g && r >= b) begin
         sec_c  = SEC_R;
         cmax_c = r;
         n_c    = $signed({1'b0, g}) - $signed({1'b0, b});
      end else if (g >= b) begin
         sec_c  = SEC_G;
         cmax_c = g;
         n_c    = $signed({1'b0, b}) - $signed({1'b0, r});
      end else begin
         sec_c  = SEC_B;
         cmax_c = b;
         n_c    = $signed({1'b0, r}) - $signed({1'b0, g});
      end
      if (r <= g && r <= b) begin
         cmin_c = r;
      end else if (g <= b) begin
         cmin_c = g;
      end else begin
         cmin_c = b;
      end
   end

   // Stage-2 combinational: hue offset per sector, scaled hue numerator and saturation numerator
   always_comb begin
      case (sec1)
         SEC_R:   off_c = (n1 < 0) ? HUE_360 : 9'd0;
         SEC_G:   off_c = HUE_120;
         SEC_B:   off_c = HUE_240;
         default: off_c = 9'd0;
      endcase
      hsum_c = NW'(n1) * $signed({{(NW-9){1'b0}}, HUE_60})
             + $signed({{(NW-9){1'b0}}, off_c}) * $signed({{(NW-CW){1'b0}}, delta1});
      hnum_c = $unsigned(hsum_c <<< HF);
      snum_c = {delta1, {CW{1'b0}}} - {{CW{1'b0}}, delta1};
   end

   rgb2hsv_div #(.NW(NW), .DW(CW), .QW(HW)) u_div_h (
      .num (hnum2),
      .den (delta2),
      .quo (hq)
   );

   rgb2hsv_div #(.NW(2*CW), .DW(CW), .QW(CW)) u_div_s (
      .num (snum2),
      .den (cmax2),
      .quo (sq)
   );

   // Pipeline registers; every stage moves together on adv and holds otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         cmax1     <= '0;
         delta1    <= '0;
         sec1      <= SEC_R;
         n1        <= '0;
         hnum2     <= '0;
         snum2     <= '0;
         delta2    <= '0;
         cmax2     <= '0;
         h3        <= '0;
         s3        <= '0;
         cmax3     <= '0;
         out_h     <= '0;
         out_s     <= '0;
         out_v     <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         cmax1     <= cmax_c;
         delta1    <= cmax_c - cmin_c;
         sec1      <= sec_c;
         n1        <= n_c;
         v2        <= v1;
         hnum2     <= hnum_c;
         snum2     <= snum_c;
         delta2    <= delta1;
         cmax2     <= cmax1;
         v3        <= v2;
         h3        <= hq;
         s3        <= sq;
         cmax3     <= cmax2;
         out_valid <= v3;
         out_h     <= h3;
         out_s     <= s3;
         out_v     <= cmax3;
      end
   end

`ifdef RGB2HSV_PIPE_CNT_EN
   // Saturating count of output transfers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cnt <= 32'd0;
      end else if (out_valid && out_ready && out_cnt != 32'hFFFF_FFFF) begin
         out_cnt <= out_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Self-checking bench for rgb2hsv_pipe: directed table, reset/latency sequences, randomized streams.
module tb_rgb2hsv_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [23:0] in_rgb;
   logic        in_ready0, out_valid0, in_ready4, out_valid4;
   logic [8:0]  h0;
   logic [12:0] h4;
   logic [7:0]  s0, v0, s4, v4;
`ifdef RGB2HSV_PIPE_CNT_EN
   logic [31:0] cnt0, cnt4;
`endif

   always #5 clk = ~clk;

   rgb2hsv_pipe #(.CW(8), .HF(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_rgb(in_rgb),
      .out_valid(out_valid0), .out_ready(out_ready), .out_h(h0), .out_s(s0), .out_v(v0)
`ifdef RGB2HSV_PIPE_CNT_EN
      , .out_cnt(cnt0)
`endif
   );

   rgb2hsv_pipe #(.CW(8), .HF(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_rgb(in_rgb),
      .out_valid(out_valid4), .out_ready(out_ready), .out_h(h4), .out_s(s4), .out_v(v4)
`ifdef RGB2HSV_PIPE_CNT_EN
      , .out_cnt(cnt4)
`endif
   );

   typedef struct {
      int r, g, b;
      int h, s, v, h4;
   } vec_t;

   typedef struct {
      int h, s, v, h4;
   } exp_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: HSV from the textbook definition using plain integer arithmetic
   function automatic exp_t ref_hsv(input int r, input int g, input int b);
      exp_t e;
      int mx, mn, d, num;
      mx = (r > g) ? r : g;
      mx = (mx > b) ? mx : b;
      mn = (r < g) ? r : g;
      mn = (mn < b) ? mn : b;
      d  = mx - mn;
      e.v = mx;
      e.s = (mx == 0) ? 0 : (255 * d) / mx;
      if (d == 0) begin
         e.h  = 0;
         e.h4 = 0;
      end else begin
         if (r == mx) begin
            num = 60 * (g - b);
            if (num < 0) num = num + 360 * d;
         end else if (g == mx) begin
            num = 60 * (b - r) + 120 * d;
         end else begin
            num = 60 * (r - g) + 240 * d;
         end
         e.h  = num / d;
         e.h4 = (num * 16) / d;
      end
      return e;
   endfunction

   // Caller is at a negedge; drives one pixel and checks it emerges exactly on the 4th edge
   task automatic apply_single(input vec_t t, input string tag);
      logic early;
      early     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_rgb    = {t.r[7:0], t.g[7:0], t.b[7:0]};
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) in_valid = 1'b0;
         if (k < 4) early = early | out_valid0 | out_valid4;
      end
      check({tag, "_early_valid"}, 64'(early), 64'(0));
      check({tag, "_valid"}, 64'(out_valid0), 64'(1));
      check({tag, "_h"}, 64'(h0), 64'(t.h));
      check({tag, "_s"}, 64'(s0), 64'(t.s));
      check({tag, "_v"}, 64'(v0), 64'(t.v));
      check({tag, "_h_hf4"}, 64'(h4), 64'(t.h4));
   endtask

   // Streams n_pix pixels; mode 0: ready toggles every 2 cycles, mode 1: random valid/ready
   task automatic stream(input int n_pix, input int mode, input string tag);
      exp_t        q[$];
      exp_t        e, p;
      int          sent, got, r, g, b;
      logic        stalled;
      logic [63:0] saved;
      sent    = 0;
      got     = 0;
      stalled = 1'b0;
      saved   = '0;
      for (int cyc = 0; cyc < 20 * n_pix + 100 && got < n_pix; cyc++) begin
         @(negedge clk);
         out_ready = (mode == 0) ? (((cyc / 2) % 2) == 0) : ($urandom_range(0, 3) != 0);
         if (sent < n_pix && (mode == 0 || $urandom_range(0, 1) == 1)) begin
            r = int'($urandom_range(0, 255));
            g = ($urandom_range(0, 3) == 0) ? r : int'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? g : int'($urandom_range(0, 255));
            in_valid = 1'b1;
            in_rgb   = {r[7:0], g[7:0], b[7:0]};
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stalled) begin
            check({tag, "_stall_hold"}, {25'd0, out_valid0, h0, s0, v0, h4}, saved);
         end
         if (in_valid && in_ready0) begin
            q.push_back(ref_hsv(int'(in_rgb[23:16]), int'(in_rgb[15:8]), int'(in_rgb[7:0])));
            sent++;
         end
         if (out_valid0 && out_ready) begin
            got++;
            if (q.size() == 0) begin
               check({tag, "_unexpected_out"}, 64'(1), 64'(0));
            end else begin
               p = q.pop_front();
               check({tag, "_h"}, 64'(h0), 64'(p.h));
               check({tag, "_s"}, 64'(s0), 64'(p.s));
               check({tag, "_v"}, 64'(v0), 64'(p.v));
               check({tag, "_h_hf4"}, 64'(h4), 64'(p.h4));
            end
         end
         stalled = out_valid0 && !out_ready;
         saved   = {25'd0, out_valid0, h0, s0, v0, h4};
      end
      in_valid = 1'b0;
      check({tag, "_out_count"}, 64'(got), 64'(n_pix));
      check({tag, "_leftover"}, 64'(q.size()), 64'(0));
      e = '{h: 0, s: 0, v: 0, h4: 0};
      if (e.h != 0) $display("unreachable");
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[9];

   initial begin
      tbl[0] = '{r: 255, g: 0,   b: 0,   h: 0,   s: 255, v: 255, h4: 0};
      tbl[1] = '{r: 0,   g: 255, b: 0,   h: 120, s: 255, v: 255, h4: 1920};
      tbl[2] = '{r: 0,   g: 0,   b: 255, h: 240, s: 255, v: 255, h4: 3840};
      tbl[3] = '{r: 255, g: 0,   b: 255, h: 300, s: 255, v: 255, h4: 4800};
      tbl[4] = '{r: 128, g: 128, b: 128, h: 0,   s: 0,   v: 128, h4: 0};
      tbl[5] = '{r: 0,   g: 0,   b: 0,   h: 0,   s: 0,   v: 0,   h4: 0};
      tbl[6] = '{r: 255, g: 128, b: 0,   h: 30,  s: 255, v: 255, h4: 481};
      tbl[7] = '{r: 10,  g: 200, b: 50,  h: 132, s: 242, v: 200, h4: 2122};
      tbl[8] = '{r: 200, g: 10,  b: 50,  h: 347, s: 242, v: 200, h4: 5557};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_rgb    = 24'd0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid0), 64'(0));
      check("reset_outputs", {31'd0, h0, s0, v0, h4}, 64'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         apply_single(tbl[i], $sformatf("table%0d", i));
      end

      // Reset with one result showing and three pixels in flight
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_rgb = {8'(i * 40 + 20), 8'(200 - i * 30), 8'(i * 17)};
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 64'(out_valid0), 64'(1));
      rst = 1'b1;
      #1;
      check("rst_async_valid", 64'(out_valid0), 64'(0));
      check("rst_async_outputs", {31'd0, h0, s0, v0, h4}, 64'(0));
      @(negedge clk);
      rst = 1'b0;
      apply_single(tbl[7], "after_rst");

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      stream(16, 0, "stream16");
`ifdef RGB2HSV_PIPE_CNT_EN
      check("cnt_after_16", 64'(cnt0), 64'(16));
`endif

      stream(300, 1, "random");

      @(negedge clk);
      rst = 1'b1;
      #1;
      check("final_rst_valid", 64'(out_valid0), 64'(0));
`ifdef RGB2HSV_PIPE_CNT_EN
      check("cnt_after_rst", 64'(cnt0), 64'(0));
`endif
      @(negedge clk);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
